// File: rtl/cart_drive_ctrl.sv
// Cart drive controller: IR commands -> ramped motor duty, direction and steering servo duty,
// with safe reversal and obstacle backoff. Define CART_WDOG_EN for the command-silence watchdog.
module cart_drive_ctrl #(
  parameter int CLK_HZ        = 25000000,
  parameter int TICK_HZ       = 256,
  parameter int MOTOR_W       = 8,
  parameter int SERVO_W       = 8,
  parameter int MOTOR_MAX     = 255,
  parameter int MOTOR_STEP    = 32,
  parameter int RAMP_STEP     = 4,
  parameter int SERVO_MIN     = 0,
  parameter int SERVO_MAX     = 255,
  parameter int SERVO_STEP    = 32,
  parameter int SERVO_CENTER  = 155,
  parameter int SERVO_AVOID   = 50,
  parameter int BACKOFF_TICKS = 251,
  parameter int WDOG_TICKS    = 512
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ir_ready,
  input  logic [31:0]        command,
  input  logic               can_move_fwd,
  output logic               ack,
  output logic               ctl_valid,
  output logic [1:0]         fsm_state,
  output logic               direction,
  output logic [MOTOR_W-1:0] motor_dc,
  output logic [SERVO_W-1:0] servo_dc
);

  localparam logic [1:0] S_OFF     = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_BACKOFF = 2'd2;

  localparam logic [31:0] C_ON     = 32'hFE010707;
  localparam logic [31:0] C_OFF    = 32'hFD020707;
  localparam logic [31:0] C_FWD    = 32'hED120707;
  localparam logic [31:0] C_REV    = 32'hEF100707;
  localparam logic [31:0] C_LEFT   = 32'h9A650707;
  localparam logic [31:0] C_RIGHT  = 32'h9D620707;
  localparam logic [31:0] C_UP     = 32'h9F600707;
  localparam logic [31:0] C_DOWN   = 32'h9E610707;
  localparam logic [31:0] C_STOP   = 32'h86790707;
  localparam logic [31:0] C_CENTRE = 32'h97680707;

  localparam int DIV   = (CLK_HZ / TICK_HZ < 1) ? 1 : CLK_HZ / TICK_HZ;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BO_W  = $clog2(BACKOFF_TICKS + 1);

  localparam logic [MOTOR_W:0]   M_MAX   = (MOTOR_W+1)'(MOTOR_MAX);
  localparam logic [MOTOR_W:0]   M_STEP  = (MOTOR_W+1)'(MOTOR_STEP);
  localparam logic [MOTOR_W:0]   M_RAMP  = (MOTOR_W+1)'(RAMP_STEP);
  localparam logic [SERVO_W:0]   SV_MINW = (SERVO_W+1)'(SERVO_MIN);
  localparam logic [SERVO_W:0]   SV_MAXW = (SERVO_W+1)'(SERVO_MAX);
  localparam logic [SERVO_W:0]   SV_STEP = (SERVO_W+1)'(SERVO_STEP);
  localparam logic [SERVO_W-1:0] SV_MIN  = SERVO_W'(SERVO_MIN);
  localparam logic [SERVO_W-1:0] SV_MAX  = SERVO_W'(SERVO_MAX);
  localparam logic [SERVO_W-1:0] SV_CTR  = SERVO_W'(SERVO_CENTER);
  localparam logic [SERVO_W-1:0] SV_AVD  = SERVO_W'(SERVO_AVOID);

  typedef struct packed {
    logic on, off, fwd, rev, left, right, up, down, stop, centre;
  } cmd_t;

  logic [DIV_W-1:0]   div_cnt;
  logic               tick;
  logic               held;
  logic               take;
  cmd_t               cmd;
  logic               req_dir;
  logic [MOTOR_W-1:0] target;
  logic [BO_W-1:0]    bo_cnt;
  logic               obstacle;
  logic               wd_fire;

  logic [1:0]         st_n;
  logic               dir_n, req_n;
  logic [MOTOR_W-1:0] tgt_n, mot_n, eff, tgt_up, tgt_dn;
  logic [SERVO_W-1:0] srv_n, srv_lt, srv_rt;
  logic [BO_W-1:0]    bo_n;
  logic [MOTOR_W:0]   m_sum;
  logic [SERVO_W:0]   s_sum;

  function automatic logic [MOTOR_W-1:0] ramp(input logic [MOTOR_W-1:0] cur,
                                               input logic [MOTOR_W-1:0] tgt);
    logic [MOTOR_W:0] diff;
    if (tgt > cur) begin
      diff = {1'b0, tgt} - {1'b0, cur};
      ramp = (diff > M_RAMP) ? MOTOR_W'({1'b0, cur} + M_RAMP) : tgt;
    end else begin
      diff = {1'b0, cur} - {1'b0, tgt};
      ramp = (diff > M_RAMP) ? MOTOR_W'({1'b0, cur} - M_RAMP) : tgt;
    end
  endfunction

  assign tick = (div_cnt == DIV_W'(DIV - 1));

  // held blocks re-sampling the same frame until ir_ready drops for a cycle
  assign take = ir_ready && !ack && !held;

  always_comb begin
    cmd        = '0;
    cmd.on     = take && (command == C_ON);
    cmd.off    = take && (command == C_OFF);
    cmd.fwd    = take && (command == C_FWD);
    cmd.rev    = take && (command == C_REV);
    cmd.left   = take && (command == C_LEFT);
    cmd.right  = take && (command == C_RIGHT);
    cmd.up     = take && (command == C_UP);
    cmd.down   = take && (command == C_DOWN);
    cmd.stop   = take && (command == C_STOP);
    cmd.centre = take && (command == C_CENTRE);
  end

  assign obstacle = (fsm_state == S_RUN) && !can_move_fwd && direction && (motor_dc != '0);

  always_comb begin
    m_sum  = {1'b0, target} + M_STEP;
    tgt_up = (m_sum > M_MAX) ? M_MAX[MOTOR_W-1:0] : m_sum[MOTOR_W-1:0];
    tgt_dn = ({1'b0, target} < M_STEP) ? '0 : MOTOR_W'({1'b0, target} - M_STEP);
    s_sum  = {1'b0, servo_dc} + SV_STEP;
    srv_lt = (s_sum > SV_MAXW) ? SV_MAX : s_sum[SERVO_W-1:0];
    srv_rt = ({1'b0, servo_dc} < SV_MINW + SV_STEP) ? SV_MIN
                                                    : SERVO_W'({1'b0, servo_dc} - SV_STEP);
  end

`ifdef CART_WDOG_EN
  localparam int WD_W = $clog2(WDOG_TICKS + 1);
  logic [WD_W-1:0] wd_cnt;

  assign wd_fire = tick && (fsm_state == S_RUN) && !take && (wd_cnt == WD_W'(WDOG_TICKS - 1));

  // saturates at the limit so the timeout fires once per silence period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            wd_cnt <= '0;
    else if (fsm_state != S_RUN || take)   wd_cnt <= '0;
    else if (tick && wd_cnt != WD_W'(WDOG_TICKS)) wd_cnt <= wd_cnt + 1'b1;
  end
`else
  assign wd_fire = 1'b0;
`endif

  always_comb begin
    st_n  = fsm_state;
    dir_n = direction;
    req_n = req_dir;
    tgt_n = target;
    mot_n = motor_dc;
    srv_n = servo_dc;
    bo_n  = bo_cnt;
    eff   = target;
    case (fsm_state)
      S_RUN: begin
        if (obstacle) begin
          st_n  = S_BACKOFF;
          mot_n = '0;
          dir_n = 1'b0;
          req_n = 1'b0;
          srv_n = SV_AVD;
          tgt_n = M_MAX[MOTOR_W-1:0];
          bo_n  = '0;
        end else begin
          if (cmd.up && (can_move_fwd || !direction)) tgt_n = tgt_up;
          if (cmd.down)   tgt_n = tgt_dn;
          if (cmd.stop)   tgt_n = '0;
          if (cmd.left)   srv_n = srv_lt;
          if (cmd.right)  srv_n = srv_rt;
          if (cmd.centre) srv_n = SV_CTR;
          if (cmd.fwd)    req_n = 1'b1;
          if (cmd.rev)    req_n = 1'b0;
          if (cmd.off) begin
            st_n  = S_OFF;
            tgt_n = '0;
            srv_n = SV_CTR;
          end
          if (wd_fire) begin
            tgt_n = '0;
            srv_n = SV_CTR;
          end
          // a pending reversal parks the motor at zero before the flip
          eff = (req_n != direction) ? '0 : tgt_n;
          if (tick) begin
            if (req_n != direction && motor_dc == '0) dir_n = req_n;
            mot_n = ramp(motor_dc, eff);
          end
        end
      end
      S_BACKOFF: begin
        if (cmd.off) begin
          st_n  = S_OFF;
          tgt_n = '0;
          srv_n = SV_CTR;
          if (tick) mot_n = ramp(motor_dc, '0);
        end else if (tick) begin
          if (bo_cnt == BO_W'(BACKOFF_TICKS - 1)) begin
            st_n  = S_RUN;
            dir_n = 1'b1;
            req_n = 1'b1;
            tgt_n = '0;
            mot_n = '0;
            srv_n = SV_CTR;
            bo_n  = '0;
          end else begin
            bo_n  = bo_cnt + 1'b1;
            mot_n = ramp(motor_dc, target);
          end
        end
      end
      default: begin
        st_n  = cmd.on ? S_RUN : S_OFF;
        tgt_n = '0;
        srv_n = SV_CTR;
        if (tick) mot_n = ramp(motor_dc, '0);
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt   <= '0;
      held      <= 1'b0;
      ack       <= 1'b0;
      ctl_valid <= 1'b0;
      fsm_state <= S_OFF;
      direction <= 1'b1;
      req_dir   <= 1'b1;
      target    <= '0;
      motor_dc  <= '0;
      servo_dc  <= SV_CTR;
      bo_cnt    <= '0;
    end else begin
      div_cnt   <= tick ? '0 : div_cnt + 1'b1;
      held      <= take | (held & ir_ready);
      ack       <= take;
      ctl_valid <= 1'b1;
      fsm_state <= st_n;
      direction <= dir_n;
      req_dir   <= req_n;
      target    <= tgt_n;
      motor_dc  <= mot_n;
      servo_dc  <= srv_n;
      bo_cnt    <= bo_n;
    end
  end

endmodule
